// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: two-channel continuous-rotation servo PWM generator.
// A free-running frame counter defines fixed-length frames. Commands and the
// enable are captured only at frame start, so a pulse never changes mid-frame.
// Optional feature macro: SERVO_SOFT_RAMP_EN. When defined, each applied
// command slews toward its target by at most RAMP_STEP per frame.

module servo_pwm_gen #(
  parameter int PERIOD_TICKS = 2000000,
  parameter int MIN_TICKS    = 100000,
  parameter int STEP_TICKS   = 392,
  parameter int INVERT_R     = 1,
  parameter int RAMP_STEP    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] speed_l,
  input  logic [7:0] speed_r,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       frame_start
);

  localparam int              CNT_W      = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int              MAX_WIDTH  = MIN_TICKS + 255 * STEP_TICKS;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [7:0]      STOP_CMD   = 8'd128;
  localparam logic [CNT_W-1:0] STOP_WIDTH = CNT_W'(MIN_TICKS + 128 * STEP_TICKS);

  // The widest pulse must end before the frame does; otherwise the output
  // would never return low and the widths would not fit the counter.
  generate
    if (MAX_WIDTH >= PERIOD_TICKS) begin : g_bad_width
      $error("servo_pwm_gen: MIN_TICKS+255*STEP_TICKS must be below PERIOD_TICKS");
    end
    if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_bad_ramp
      $error("servo_pwm_gen: RAMP_STEP must be in 1..255");
    end
  endgenerate

  // Pulse width for an applied command. Evaluated in 32-bit arithmetic; the
  // elaboration check above guarantees the result fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] width_of(input logic [7:0] cmd);
    int w;
    w = MIN_TICKS + int'(cmd) * STEP_TICKS;
    return w[CNT_W-1:0];
  endfunction

`ifdef SERVO_SOFT_RAMP_EN
  // Move cur toward tgt by at most RAMP_STEP, landing exactly on tgt when close.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
    int diff;
    int nxt;
    diff = int'(tgt) - int'(cur);
    if (diff > RAMP_STEP) begin
      nxt = int'(cur) + RAMP_STEP;
    end else if (diff < -RAMP_STEP) begin
      nxt = int'(cur) - RAMP_STEP;
    end else begin
      nxt = int'(tgt);
    end
    return nxt[7:0];
  endfunction
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;
  logic             en_lat_q, en_lat_d;
  logic             frame_start_q, frame_start_d;

  // Frame counter next state; the enable is captured on the wrap edge only.
  always_comb begin
    wrap          = (cnt_q == CNT_LAST);
    cnt_d         = wrap ? '0 : cnt_q + 1'b1;
    en_lat_d      = wrap ? en : en_lat_q;
    frame_start_d = (cnt_d == '0);
  end

  // Counter, enable latch and frame strobe registers. Reset parks the counter
  // on its last value so the first released edge opens a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= CNT_LAST;
      en_lat_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      en_lat_q      <= en_lat_d;
      frame_start_q <= frame_start_d;
    end
  end

  // One identical channel per wheel: index 0 is left, index 1 is right.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [7:0]       target;
      logic [7:0]       applied_q, applied_d;
      logic [CNT_W-1:0] width_q, width_d;
      logic             pwm_q, pwm_d;

      if (gi == 0) begin : g_left
        assign target = speed_l;
      end else if (INVERT_R != 0) begin : g_right_mirror
        // Right servo is mounted mirrored, so its command runs backwards.
        assign target = 8'd255 - speed_r;
      end else begin : g_right_direct
        assign target = speed_r;
      end

      // Applied command/width update at frame start and pulse lookahead decode.
      always_comb begin
        applied_d = applied_q;
        width_d   = width_q;
        if (wrap) begin
`ifdef SERVO_SOFT_RAMP_EN
          applied_d = ramp_toward(applied_q, target);
`else
          applied_d = target;
`endif
          width_d = width_of(applied_d);
        end
        pwm_d = en_lat_d & (cnt_d < width_d);
      end

      // Channel state registers; the pulse output comes straight from pwm_q.
      always_ff @(posedge clk) begin
        if (rst) begin
          applied_q <= STOP_CMD;
          width_q   <= STOP_WIDTH;
          pwm_q     <= 1'b0;
        end else begin
          applied_q <= applied_d;
          width_q   <= width_d;
          pwm_q     <= pwm_d;
        end
      end
    end
  endgenerate

  assign pwm_l       = g_ch[0].pwm_q;
  assign pwm_r       = g_ch[1].pwm_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Testbench for servo_pwm_gen. A reference model pushes one expected frame
// (enable and both pulse widths) per frame start; a monitor measures each
// frame from the DUT outputs and pops/compares when the next frame begins.

module tb_servo_pwm_gen;

  localparam int P    = 1000;
  localparam int MINT = 100;
  localparam int STEP = 1;
  localparam int INV  = 1;
  localparam int RAMP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] speed_l;
  logic [7:0] speed_r;
  logic       pwm_l;
  logic       pwm_r;
  logic       frame_start;

  servo_pwm_gen #(
    .PERIOD_TICKS(P),
    .MIN_TICKS   (MINT),
    .STEP_TICKS  (STEP),
    .INVERT_R    (INV),
    .RAMP_STEP   (RAMP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .speed_l    (speed_l),
    .speed_r    (speed_r),
    .pwm_l      (pwm_l),
    .pwm_r      (pwm_r),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_frames = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    bit en;
    int wl;
    int wr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a frame begins every P released clock edges, the first
  // one on the edge right after reset is released. Widths from the rules.
  function automatic int next_applied(input int cur, input int tgt);
`ifdef SERVO_SOFT_RAMP_EN
    if (tgt > cur) return cur + ((tgt - cur) < RAMP ? (tgt - cur) : RAMP);
    else           return cur - ((cur - tgt) < RAMP ? (cur - tgt) : RAMP);
`else
    return tgt + 0 * cur;
`endif
  endfunction

  initial begin : model
    int edges_since;
    int al, ar, tl, tr;
    exp_t e;
    edges_since = -1;
    al = 128;
    ar = 128;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        edges_since = -1;
        al = 128;
        ar = 128;
      end else begin
        edges_since++;
        if (edges_since % P == 0) begin
          tl = int'(speed_l);
          tr = (INV != 0) ? 255 - int'(speed_r) : int'(speed_r);
          al = next_applied(al, tl);
          ar = next_applied(ar, tr);
          e.en = en;
          e.wl = MINT + al * STEP;
          e.wr = MINT + ar * STEP;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    bit   measuring;
    bit   prev_rst;
    int   len, hi_l, hi_r;
    bit   low_l, low_r, gap_l, gap_r;
    exp_t e;
    measuring = 0;
    prev_rst  = 0;
    len = 0; hi_l = 0; hi_r = 0;
    low_l = 0; low_r = 0; gap_l = 0; gap_r = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_pwm_l", int'(pwm_l), 0);
        check("rst_pwm_r", int'(pwm_r), 0);
        check("rst_frame_start", int'(frame_start), 0);
        measuring = 0;
        prev_rst  = 1;
      end else begin
        if (prev_rst) check("frame_start_after_rst", int'(frame_start), 1);
        prev_rst = 0;
        if (frame_start) begin
          if (measuring) begin
            if (exp_q.size() == 0) begin
              check("expected_frame_available", 0, 1);
            end else begin
              e = exp_q.pop_front();
              n_frames++;
              $display("frame %0d: en=%0d len=%0d pwm_l=%0d/%0d pwm_r=%0d/%0d",
                       n_frames, e.en, len, hi_l, e.en ? e.wl : 0, hi_r, e.en ? e.wr : 0);
              check("frame_len", len, P);
              check("pwm_l_width", hi_l, e.en ? e.wl : 0);
              check("pwm_r_width", hi_r, e.en ? e.wr : 0);
              check("pwm_l_single_pulse", int'(gap_l), 0);
              check("pwm_r_single_pulse", int'(gap_r), 0);
            end
          end
          measuring = 1;
          len = 0; hi_l = 0; hi_r = 0;
          low_l = 0; low_r = 0; gap_l = 0; gap_r = 0;
        end
        if (measuring) begin
          len++;
          if (pwm_l) begin
            if (low_l) gap_l = 1;
            hi_l++;
          end else begin
            low_l = 1;
          end
          if (pwm_r) begin
            if (low_r) gap_r = 1;
            hi_r++;
          end else begin
            low_r = 1;
          end
          if (len == P + 1) check("frame_start_timeout", len, P);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the negedge where frame_start is high (cnt == 0).
  task automatic sync_frame();
    int k;
    k = 0;
    @(negedge clk);
    while (!frame_start && k < 2 * P) begin
      @(negedge clk);
      k++;
    end
    if (!frame_start) check("sync_frame_timeout", int'(frame_start), 1);
  endtask

  typedef struct {
    bit         en;
    logic [7:0] sl;
    logic [7:0] sr;
  } cmd_t;

  cmd_t table_cmds[4] = '{
    '{1'b1, 8'd0,   8'd0},
    '{1'b1, 8'd128, 8'd128},
    '{1'b1, 8'd255, 8'd255},
    '{1'b1, 8'd255, 8'd0}
  };

  initial begin : stimulus
    rst = 1'b1;
    en = 1'b1;
    speed_l = 8'd0;
    speed_r = 8'd0;
    cycles(3);
    rst = 1'b0;

    // Boundary and nominal commands, two frames each.
    foreach (table_cmds[i]) begin
      en      = table_cmds[i].en;
      speed_l = table_cmds[i].sl;
      speed_r = table_cmds[i].sr;
      sync_frame();
      sync_frame();
    end

    // Mid-frame command change only affects the next frame.
    speed_l = 8'd0;
    sync_frame();
    sync_frame();
    cycles(50);
    speed_l = 8'd255;
    sync_frame();

    // Enable low at a frame start, raised again mid-frame.
    cycles(P - 2);
    en = 1'b0;
    cycles(500);
    en = 1'b1;
    sync_frame();
    sync_frame();

    // Reset in the middle of a 200-cycle pulse.
    speed_l = 8'd100;
    sync_frame();
    sync_frame();
    cycles(60);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    sync_frame();

    // Large step on the left command, held long enough for any slewing to settle.
    speed_l = 8'd128;
    sync_frame();
    sync_frame();
    speed_l = 8'd200;
    repeat (10) sync_frame();

    // Random commands changed at random points in the frame.
    for (int i = 0; i < 20; i++) begin
      en      = ($urandom_range(0, 5) != 0);
      speed_l = 8'($urandom_range(0, 255));
      speed_r = 8'($urandom_range(0, 255));
      cycles($urandom_range(50, 1500));
    end
    en = 1'b1;
    sync_frame();
    sync_frame();
    cycles(2);

    check("frames_observed_min", (n_frames >= 40) ? 1 : 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
